bcd_addsub_serial: RTL

//   Digit-serial N-digit packed-BCD adder/subtractor with valid/ready handshakes on both sides.
//   - Successor to the combinational 2-digit BCD adder.
//   - One BCD digit per clock, least-significant digit first, through a single reused digit cell.
//   - Adds add/subtract mode and backpressure.
//   - Sits between operand producers (keypad/registers) and BCD display or accumulator logic.

---
 rtl/bcd_addsub_serial_if.sv | 26 ++
 rtl/bcd_addsub_serial.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_serial_if.sv
// Handshake bundle for the digit-serial BCD adder/subtractor.
// The producer/consumer side uses master; the arithmetic block uses slave.
interface bcd_addsub_serial_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sub;
    logic [4*DIGITS-1:0]   in_a;
    logic [4*DIGITS-1:0]   in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_sum;
    logic                  out_cout;
    logic                  out_err;

    modport master (
        output in_valid, in_sub, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_err
    );

    modport slave (
        input  in_valid, in_sub, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_err
    );
endinterface

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional invalid-digit check is enabled by defining BCD_INPUT_CHECK_EN.
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_addsub_serial_if.slave    bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    logic [3:0]         a_dig, b_dig, b_eff, dig;
    logic [4:0]         t, t_adj;
    logic               dig_carry;
    logic               accept;

    assign accept = (state_q == IDLE) && bus.in_valid;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        // Single shared digit cell: select digit idx, nine's complement B when subtracting.
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
        t     = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry_q};
        t_adj = t - 5'd10;
        if (t > 5'd9) begin
            dig       = t_adj[3:0];
            dig_carry = 1'b1;
        end else begin
            dig       = t[3:0];
            dig_carry = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    sub_d   = bus.in_sub;
                    idx_d   = '0;
                    carry_d = bus.in_sub;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = dig;
                end
                carry_d = dig_carry;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    cout_d  = sub_q ? ~dig_carry : dig_carry;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
        end
    end

    // NOTE: operand registers are always written at acceptance before use, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_q, err_d;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        err_d = err_q;
        if (accept) err_d = has_bad_digit(bus.in_a) | has_bad_digit(bus.in_b);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif

    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
endmodule
